// File: rtl/relu_maxpool3x3s2_pkg.sv
// Shared types and helpers for the ReLU + 3x3/stride-2 max-pool stage.
// Samples are signed Q8.8; all comparisons are full-width signed.
package relu_maxpool_pkg;

    localparam int DATWIDTH = 16;

    typedef logic signed [DATWIDTH-1:0] sample_t;

    localparam sample_t Q_MIN = 16'h8000;

    function automatic sample_t smax(input sample_t a, input sample_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic int outSize(input int inSize);
        return (inSize - 1) / 2;
    endfunction

    // Index width that stays >= 1 bit for degenerate sizes.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/relu_maxpool3x3s2_if.sv
// Sample stream into the pool stage and pooled stream plus status out of it.
interface relu_maxpool3x3s2_if;
    import relu_maxpool_pkg::*;

    sample_t i_data;
    logic    i_data_valid;
    sample_t o_pooled_data;
    logic    o_pooled_data_valid;
    logic    o_plane_done;
    logic    o_frame_done;
    logic    o_busy;

    modport master (
        output i_data, i_data_valid,
        input  o_pooled_data, o_pooled_data_valid, o_plane_done, o_frame_done, o_busy
    );

    modport slave (
        input  i_data, i_data_valid,
        output o_pooled_data, o_pooled_data_valid, o_plane_done, o_frame_done, o_busy
    );

endinterface

// File: rtl/relu_maxpool3x3s2_row_buffer.sv
// One line of partial vertical maxima, one entry per pooled column.
// Combinational read and synchronous write at the same index: read-before-write.
module pool_row_buffer #(
    parameter int DEPTH = 27,
    parameter int WIDTH = 16,
    parameter int IW    = 5
) (
    input  logic             clk,
    input  logic [IW-1:0]    idx,
    input  logic             wrEn,
    input  logic [WIDTH-1:0] wrData,
    output logic [WIDTH-1:0] rdData
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rdData = mem[idx];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[idx] <= wrData;
        end
    end

endmodule

// File: rtl/relu_maxpool3x3s2.sv
// Streaming ReLU + 3x3/stride-2 max-pool over raster-ordered planes; 1-cycle registered output.
// No backpressure: one sample accepted every valid cycle, gaps hold all state.
module relu_maxpool3x3s2 #(
    parameter int DATWIDTH  = relu_maxpool_pkg::DATWIDTH,
    parameter int INPUTSIZE = 55,
    parameter int CHANNELS  = 64,
    parameter int RELU      = 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    relu_maxpool3x3s2_if.slave  bus
);
    import relu_maxpool_pkg::*;

    localparam int OUTPUTSIZE = outSize(INPUTSIZE);
    localparam int CW         = idxWidth(INPUTSIZE);
    localparam int OW         = idxWidth(OUTPUTSIZE);
    localparam int HW         = idxWidth(CHANNELS);

    logic [CW-1:0] col;
    logic [CW-1:0] row;
    logic [HW-1:0] chan;
    sample_t       hmax;

    sample_t       x;
    logic          vld;
    logic          colLast, rowLast, chanLast;
    logic          hDone, outFire, planeLast;
    logic [OW-1:0] ox;
    sample_t       hWin, vWin, pendRd, pendWr, result;

    sample_t       pooledData;
    logic          pooledValid, planeDone, frameDone, busy;

    assign x   = bus.i_data;
    assign vld = bus.i_data_valid;

    always_comb begin
        colLast   = (col == CW'(INPUTSIZE - 1));
        rowLast   = (row == CW'(INPUTSIZE - 1));
        chanLast  = (chan == HW'(CHANNELS - 1));
        hWin      = smax(hmax, x);
        // Even columns past 0 close a horizontal window that also seeds the next one.
        hDone     = vld && !col[0] && (col != '0);
        ox        = OW'((col >> 1) - CW'(1));
        vWin      = smax(pendRd, hWin);
        pendWr    = smax(row[0] ? pendRd : Q_MIN, hWin);
        outFire   = hDone && !row[0] && (row != '0);
        planeLast = outFire && colLast && rowLast;
        result    = (RELU != 0 && vWin[$bits(sample_t)-1]) ? sample_t'(0) : vWin;
    end

    pool_row_buffer #(
        .DEPTH (OUTPUTSIZE),
        .WIDTH (DATWIDTH),
        .IW    (OW)
    ) u_rowBuf (
        .clk    (i_clk),
        .idx    (ox),
        .wrEn   (hDone),
        .wrData (pendWr),
        .rdData (pendRd)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col         <= '0;
            row         <= '0;
            chan        <= '0;
            hmax        <= '0;
            pooledData  <= '0;
            pooledValid <= 1'b0;
            planeDone   <= 1'b0;
            frameDone   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            pooledValid <= outFire;
            planeDone   <= planeLast;
            frameDone   <= planeLast && chanLast;
            if (outFire) begin
                pooledData <= result;
            end
            if (vld) begin
                hmax <= col[0] ? hWin : x;
                if (colLast) begin
                    col <= '0;
                    if (rowLast) begin
                        row  <= '0;
                        chan <= chanLast ? '0 : chan + HW'(1);
                    end else begin
                        row <= row + CW'(1);
                    end
                end else begin
                    col <= col + CW'(1);
                end
            end
            if (planeLast && chanLast) begin
                busy <= 1'b0;
            end else if (vld) begin
                busy <= 1'b1;
            end
        end
    end

    assign bus.o_pooled_data       = pooledData;
    assign bus.o_pooled_data_valid = pooledValid;
    assign bus.o_plane_done        = planeDone;
    assign bus.o_frame_done        = frameDone;
    assign bus.o_busy              = busy;

endmodule

// File: tb/tb_relu_maxpool3x3s2.sv
// Bench for relu_maxpool3x3s2: three 5x5 instances (ReLU/1ch, signed/1ch, ReLU/2ch)
// share one input stream; outputs are compared with a window-max model.
module tb_relu_maxpool3x3s2;
    import relu_maxpool_pkg::*;

    localparam int IS = 5;
    localparam int OS = 2;

    typedef struct {
        sample_t d;
        logic    pd;
        logic    fd;
        logic    busy;
        int      cyc;
    } obs_t;

    logic    clk = 1'b0;
    logic    rst_n;
    sample_t drvData;
    logic    drvValid;
    int      cyc = 0;
    int      nTests = 0;
    int      nFail = 0;

    sample_t img    [2][IS][IS];
    int      accCyc [2][IS][IS];
    obs_t    capA[$], capB[$], capC[$], expQ[$];

    relu_maxpool3x3s2_if ifA();
    relu_maxpool3x3s2_if ifB();
    relu_maxpool3x3s2_if ifC();

    assign ifA.i_data = drvData;
    assign ifB.i_data = drvData;
    assign ifC.i_data = drvData;
    assign ifA.i_data_valid = drvValid;
    assign ifB.i_data_valid = drvValid;
    assign ifC.i_data_valid = drvValid;

    relu_maxpool3x3s2 #(.DATWIDTH(16), .INPUTSIZE(IS), .CHANNELS(1), .RELU(1)) dutA (
        .i_clk(clk), .i_rst_n(rst_n), .bus(ifA));
    relu_maxpool3x3s2 #(.DATWIDTH(16), .INPUTSIZE(IS), .CHANNELS(1), .RELU(0)) dutB (
        .i_clk(clk), .i_rst_n(rst_n), .bus(ifB));
    relu_maxpool3x3s2 #(.DATWIDTH(16), .INPUTSIZE(IS), .CHANNELS(2), .RELU(1)) dutC (
        .i_clk(clk), .i_rst_n(rst_n), .bus(ifC));

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (ifA.o_pooled_data_valid)
            capA.push_back('{ifA.o_pooled_data, ifA.o_plane_done, ifA.o_frame_done, ifA.o_busy, cyc});
        if (ifB.o_pooled_data_valid)
            capB.push_back('{ifB.o_pooled_data, ifB.o_plane_done, ifB.o_frame_done, ifB.o_busy, cyc});
        if (ifC.o_pooled_data_valid)
            capC.push_back('{ifC.o_pooled_data, ifC.o_plane_done, ifC.o_frame_done, ifC.o_busy, cyc});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic resetAll();
        @(negedge clk);
        rst_n    = 1'b0;
        drvValid = 1'b0;
        drvData  = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        capA.delete();
        capB.delete();
        capC.delete();
    endtask

    // Streams nPl planes from img; gapPct is the chance of an idle cycle before each sample.
    task automatic driveFrame(input int nPl, input int gapPct);
        for (int ch = 0; ch < nPl; ch++)
            for (int r = 0; r < IS; r++)
                for (int c = 0; c < IS; c++) begin
                    for (int g = 0; g < 3 && $urandom_range(99) < gapPct; g++) begin
                        @(negedge clk);
                        drvValid = 1'b0;
                        drvData  = sample_t'($urandom);
                    end
                    @(negedge clk);
                    drvValid = 1'b1;
                    drvData  = img[ch][r][c];
                    accCyc[ch][r][c] = cyc + 1;
                end
        @(negedge clk);
        drvValid = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Reference: plain 3x3 window maxima in output raster order.
    task automatic buildExp(input int nPl, input int chans, input bit relu);
        obs_t    e;
        sample_t m;
        expQ.delete();
        for (int ch = 0; ch < nPl; ch++)
            for (int oy = 0; oy < OS; oy++)
                for (int ox = 0; ox < OS; ox++) begin
                    m = img[ch][2*oy][2*ox];
                    for (int dy = 0; dy < 3; dy++)
                        for (int dx = 0; dx < 3; dx++)
                            if (img[ch][2*oy+dy][2*ox+dx] > m) m = img[ch][2*oy+dy][2*ox+dx];
                    if (relu && m < 0) m = '0;
                    e.d    = m;
                    e.pd   = (oy == OS-1) && (ox == OS-1);
                    e.fd   = e.pd && ((ch % chans) == chans-1);
                    e.busy = !e.fd;
                    e.cyc  = accCyc[ch][2*oy+2][2*ox+2];
                    expQ.push_back(e);
                end
    endtask

    task automatic fillRamp(input int ch, input int offs);
        for (int r = 0; r < IS; r++)
            for (int c = 0; c < IS; c++)
                img[ch][r][c] = sample_t'(r*IS + c + offs);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drvValid = 1'b0;
        drvData = '0;
        #1;
        nTests++;
        if ({ifA.o_pooled_data, ifA.o_pooled_data_valid, ifA.o_plane_done, ifA.o_frame_done, ifA.o_busy} !== '0) begin
            nFail++; $display("FAIL reset_A: got %h valid=%b busy=%b want all 0", ifA.o_pooled_data, ifA.o_pooled_data_valid, ifA.o_busy);
        end
        nTests++;
        if ({ifB.o_pooled_data, ifB.o_pooled_data_valid, ifB.o_plane_done, ifB.o_frame_done, ifB.o_busy} !== '0) begin
            nFail++; $display("FAIL reset_B: got %h valid=%b busy=%b want all 0", ifB.o_pooled_data, ifB.o_pooled_data_valid, ifB.o_busy);
        end
        nTests++;
        if ({ifC.o_pooled_data, ifC.o_pooled_data_valid, ifC.o_plane_done, ifC.o_frame_done, ifC.o_busy} !== '0) begin
            nFail++; $display("FAIL reset_C: got %h valid=%b busy=%b want all 0", ifC.o_pooled_data, ifC.o_pooled_data_valid, ifC.o_busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ramp();
        sample_t known [4];
        known[0] = 16'd12; known[1] = 16'd14; known[2] = 16'd22; known[3] = 16'd24;
        resetAll();
        fillRamp(0, 0);
        driveFrame(1, 0);
        buildExp(1, 1, 1'b1);
        nTests++;
        if (capA.size() != 4) begin
            nFail++; $display("FAIL ramp_count: got %0d want 4", capA.size());
        end
        for (int i = 0; i < 4 && i < capA.size(); i++) begin
            nTests++;
            if (capA[i].d !== known[i] || capA[i].pd !== expQ[i].pd || capA[i].fd !== expQ[i].fd ||
                capA[i].busy !== expQ[i].busy || capA[i].cyc != expQ[i].cyc) begin
                nFail++;
                $display("FAIL ramp_out[%0d]: got d=%0d pd=%b fd=%b busy=%b cyc=%0d want d=%0d pd=%b fd=%b busy=%b cyc=%0d",
                         i, capA[i].d, capA[i].pd, capA[i].fd, capA[i].busy, capA[i].cyc,
                         known[i], expQ[i].pd, expQ[i].fd, expQ[i].busy, expQ[i].cyc);
            end
        end
    endtask

    task automatic test_negative();
        resetAll();
        for (int r = 0; r < IS; r++)
            for (int c = 0; c < IS; c++)
                img[0][r][c] = 16'hFF00;
        driveFrame(1, 0);
        buildExp(1, 1, 1'b1);
        nTests++;
        if (capA.size() != expQ.size()) begin
            nFail++; $display("FAIL neg_relu_count: got %0d want %0d", capA.size(), expQ.size());
        end
        for (int i = 0; i < expQ.size() && i < capA.size(); i++) begin
            nTests++;
            if (capA[i].d !== expQ[i].d || capA[i].cyc != expQ[i].cyc) begin
                nFail++;
                $display("FAIL neg_relu[%0d]: got d=%h cyc=%0d want d=%h cyc=%0d", i, capA[i].d, capA[i].cyc, expQ[i].d, expQ[i].cyc);
            end
        end
        buildExp(1, 1, 1'b0);
        nTests++;
        if (capB.size() != expQ.size()) begin
            nFail++; $display("FAIL neg_signed_count: got %0d want %0d", capB.size(), expQ.size());
        end
        for (int i = 0; i < expQ.size() && i < capB.size(); i++) begin
            nTests++;
            if (capB[i].d !== expQ[i].d || capB[i].cyc != expQ[i].cyc) begin
                nFail++;
                $display("FAIL neg_signed[%0d]: got d=%h cyc=%0d want d=%h cyc=%0d", i, capB[i].d, capB[i].cyc, expQ[i].d, expQ[i].cyc);
            end
        end
    endtask

    task automatic test_spike();
        resetAll();
        for (int r = 0; r < IS; r++)
            for (int c = 0; c < IS; c++)
                img[0][r][c] = 16'hFFFF;
        img[0][2][2] = 16'h0100;
        driveFrame(1, 0);
        buildExp(1, 1, 1'b0);
        nTests++;
        if (capB.size() != expQ.size()) begin
            nFail++; $display("FAIL spike_count: got %0d want %0d", capB.size(), expQ.size());
        end
        for (int i = 0; i < expQ.size() && i < capB.size(); i++) begin
            nTests++;
            if (capB[i].d !== expQ[i].d || capB[i].pd !== expQ[i].pd || capB[i].fd !== expQ[i].fd) begin
                nFail++;
                $display("FAIL spike[%0d]: got d=%h pd=%b fd=%b want d=%h pd=%b fd=%b",
                         i, capB[i].d, capB[i].pd, capB[i].fd, expQ[i].d, expQ[i].pd, expQ[i].fd);
            end
        end
    endtask

    task automatic test_gaps();
        resetAll();
        fillRamp(0, 0);
        driveFrame(1, 50);
        buildExp(1, 1, 1'b1);
        nTests++;
        if (capA.size() != expQ.size()) begin
            nFail++; $display("FAIL gaps_count: got %0d want %0d", capA.size(), expQ.size());
        end
        for (int i = 0; i < expQ.size() && i < capA.size(); i++) begin
            nTests++;
            if (capA[i].d !== expQ[i].d || capA[i].pd !== expQ[i].pd || capA[i].fd !== expQ[i].fd ||
                capA[i].cyc != expQ[i].cyc) begin
                nFail++;
                $display("FAIL gaps[%0d]: got d=%0d pd=%b fd=%b cyc=%0d want d=%0d pd=%b fd=%b cyc=%0d",
                         i, capA[i].d, capA[i].pd, capA[i].fd, capA[i].cyc, expQ[i].d, expQ[i].pd, expQ[i].fd, expQ[i].cyc);
            end
        end
    endtask

    task automatic test_back_to_back();
        resetAll();
        fillRamp(0, 0);
        fillRamp(1, 100);
        driveFrame(2, 0);
        buildExp(2, 2, 1'b1);
        nTests++;
        if (capC.size() != 8) begin
            nFail++; $display("FAIL b2b_count: got %0d want 8", capC.size());
        end
        for (int i = 0; i < expQ.size() && i < capC.size(); i++) begin
            nTests++;
            if (capC[i].d !== expQ[i].d || capC[i].pd !== expQ[i].pd || capC[i].fd !== expQ[i].fd ||
                capC[i].busy !== expQ[i].busy || capC[i].cyc != expQ[i].cyc) begin
                nFail++;
                $display("FAIL b2b[%0d]: got d=%0d pd=%b fd=%b busy=%b cyc=%0d want d=%0d pd=%b fd=%b busy=%b cyc=%0d",
                         i, capC[i].d, capC[i].pd, capC[i].fd, capC[i].busy, capC[i].cyc,
                         expQ[i].d, expQ[i].pd, expQ[i].fd, expQ[i].busy, expQ[i].cyc);
            end
        end
        nTests++;
        if (ifC.o_busy !== 1'b0) begin
            nFail++; $display("FAIL b2b_idle_busy: got %b want 0", ifC.o_busy);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            resetAll();
            for (int ch = 0; ch < 2; ch++)
                for (int r = 0; r < IS; r++)
                    for (int c = 0; c < IS; c++)
                        img[ch][r][c] = sample_t'($urandom);
            driveFrame(2, 30);
            buildExp(2, 2, 1'b1);
            nTests++;
            if (capC.size() != expQ.size()) begin
                nFail++; $display("FAIL rnd_relu_count[%0d]: got %0d want %0d", it, capC.size(), expQ.size());
            end
            for (int i = 0; i < expQ.size() && i < capC.size(); i++) begin
                nTests++;
                if (capC[i].d !== expQ[i].d || capC[i].pd !== expQ[i].pd || capC[i].fd !== expQ[i].fd ||
                    capC[i].busy !== expQ[i].busy || capC[i].cyc != expQ[i].cyc) begin
                    nFail++;
                    $display("FAIL rnd_relu[%0d.%0d]: got d=%h pd=%b fd=%b busy=%b cyc=%0d want d=%h pd=%b fd=%b busy=%b cyc=%0d",
                             it, i, capC[i].d, capC[i].pd, capC[i].fd, capC[i].busy, capC[i].cyc,
                             expQ[i].d, expQ[i].pd, expQ[i].fd, expQ[i].busy, expQ[i].cyc);
                end
            end
            buildExp(2, 1, 1'b0);
            nTests++;
            if (capB.size() != expQ.size()) begin
                nFail++; $display("FAIL rnd_signed_count[%0d]: got %0d want %0d", it, capB.size(), expQ.size());
            end
            for (int i = 0; i < expQ.size() && i < capB.size(); i++) begin
                nTests++;
                if (capB[i].d !== expQ[i].d || capB[i].pd !== expQ[i].pd || capB[i].fd !== expQ[i].fd ||
                    capB[i].busy !== expQ[i].busy || capB[i].cyc != expQ[i].cyc) begin
                    nFail++;
                    $display("FAIL rnd_signed[%0d.%0d]: got d=%h pd=%b fd=%b busy=%b cyc=%0d want d=%h pd=%b fd=%b busy=%b cyc=%0d",
                             it, i, capB[i].d, capB[i].pd, capB[i].fd, capB[i].busy, capB[i].cyc,
                             expQ[i].d, expQ[i].pd, expQ[i].fd, expQ[i].busy, expQ[i].cyc);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        resetAll();
        fillRamp(0, 0);
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            drvValid = 1'b1;
            drvData  = img[0][k / IS][k % IS];
        end
        @(negedge clk);
        drvValid = 1'b0;
        #2;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            nTests++;
            if ({ifA.o_pooled_data, ifA.o_pooled_data_valid, ifA.o_plane_done, ifA.o_frame_done, ifA.o_busy} !== '0) begin
                nFail++;
                $display("FAIL midrst_hold[%0d]: got d=%h valid=%b busy=%b want all 0", k, ifA.o_pooled_data, ifA.o_pooled_data_valid, ifA.o_busy);
            end
            @(negedge clk);
        end
        rst_n = 1'b1;
        capA.delete();
        driveFrame(1, 0);
        buildExp(1, 1, 1'b1);
        nTests++;
        if (capA.size() != 4) begin
            nFail++; $display("FAIL midrst_count: got %0d want 4", capA.size());
        end
        for (int i = 0; i < expQ.size() && i < capA.size(); i++) begin
            nTests++;
            if (capA[i].d !== expQ[i].d || capA[i].pd !== expQ[i].pd || capA[i].fd !== expQ[i].fd ||
                capA[i].cyc != expQ[i].cyc) begin
                nFail++;
                $display("FAIL midrst[%0d]: got d=%0d pd=%b fd=%b cyc=%0d want d=%0d pd=%b fd=%b cyc=%0d",
                         i, capA[i].d, capA[i].pd, capA[i].fd, capA[i].cyc, expQ[i].d, expQ[i].pd, expQ[i].fd, expQ[i].cyc);
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        drvValid = 1'b0;
        drvData  = '0;
        test_reset();
        test_ramp();
        test_negative();
        test_spike();
        test_gaps();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/relu_maxpool3x3s2.md
Name: relu_maxpool3x3s2

Overview:
- Streaming ReLU + 3x3/stride-2 max-pool stage. Sits directly downstream of the 1x1 convolution stage.
- Consumes that stage's output: signed Q8.8 samples, one output-channel plane at a time, in raster order (line by line, cell by cell), qualified by a valid strobe.
- Produces pooled, optionally rectified samples in raster order for the next fire/conv stage.
- Default geometry: 55x55x64 in, 27x27x64 out.

Parameters:
- DATWIDTH, 16, sample width (signed Q8.8).
- INPUTSIZE, 55, input plane width = height; must be odd and >= 3.
- OUTPUTSIZE, (INPUTSIZE-1)/2, pooled plane width = height; derived, not overridden.
- CHANNELS, 64, planes per frame.
- RELU, 1, 1 = clamp negative results to 0; 0 = pass signed max through.

Ports:
- i_clk, input, 1, clock; all state updates on rising edge.
- i_rst_n, input, 1, reset; asynchronous, active-low.
- i_data, input, DATWIDTH, signed Q8.8 sample from the conv stage.
- i_data_valid, input, 1, i_data is valid this cycle.
- o_pooled_data, output, DATWIDTH, pooled sample.
- o_pooled_data_valid, output, 1, o_pooled_data is valid this cycle (single-cycle strobe).
- o_plane_done, output, 1, pulses with the last pooled sample of each plane.
- o_frame_done, output, 1, pulses with the last pooled sample of plane CHANNELS-1.
- o_busy, output, 1, high from the first accepted sample until the frame completes.

Behaviour:
- Reset (async assert, sync release): every output is 0; col, row and channel counters are 0; hmax register is 0; row buffer contents are don't-care.
- Only cycles with i_data_valid=1 advance the counters. Gaps of any length are allowed and hold all state.
- Counters:
  - col runs 0..INPUTSIZE-1.
  - row increments when col wraps, range 0..INPUTSIZE-1.
  - chan increments when row and col both wrap, range 0..CHANNELS-1.
  - chan wraps to 0 after CHANNELS-1; the next frame starts with no idle cycle.
- Horizontal stage (per accepted sample at col c):
  - c==0: hmax <= x.
  - c odd: hmax <= max(hmax, x).
  - c even, c>0: window h = max(hmax, x) is complete for ox=(c-2)/2; then hmax <= x, because column c is shared with the next window.
- Vertical stage (on each complete h, index ox, row r):
  - r==0: pend[ox] <= h.
  - r odd: pend[ox] <= max(pend[ox], h).
  - r even, r>0: result = max(pend[ox], h) for output row (r-2)/2; then pend[ox] <= h.
- All comparisons are signed, full DATWIDTH. No rounding or scaling.
- Output:
  - When RELU=1, o_pooled_data <= (result<0) ? 0 : result; otherwise result unchanged.
  - o_pooled_data and o_pooled_data_valid are registered, asserted the cycle after the input sample that completes the window. Latency is 1 cycle.
  - o_pooled_data holds its last value when valid is low.
- Done flags and busy:
  - o_plane_done is asserted with the output where ox=oy=OUTPUTSIZE-1.
  - o_frame_done is asserted additionally when chan==CHANNELS-1.
  - o_busy is set on the first accepted sample of a frame and cleared in the same cycle o_frame_done asserts.
- Throughput: one sample accepted per cycle, unconditionally. There is no backpressure.
- Reset mid-plane discards the partial plane and frame; the next valid sample is treated as row 0, col 0, chan 0.
- Outputs per plane: OUTPUTSIZE^2 (729 at default).

Decomposition:
- Package relu_maxpool_pkg holds:
  - DATWIDTH and the Q8.8 sample typedef.
  - Constant Q_MIN = 16'h8000.
  - A signed max function.
  - The OUTPUTSIZE derivation function.
- Sub-module pool_row_buffer: OUTPUTSIZE x DATWIDTH storage, one synchronous write port and one read port, same index.
  - Read-before-write within a cycle; both the read-for-combine and the write-seed use index ox in the same cycle.
  - Registers or inferred RAM.

Test Plan:
- INPUTSIZE=5, CHANNELS=1, RELU=1, continuous valid, x=r*5+c -> exactly 4 outputs: 12, 14, 22, 24. o_plane_done and o_frame_done on the 4th. Each output appears 1 cycle after inputs (2,2), (2,4), (4,2), (4,4).
- Same plane with all samples 16'hFF00 (-1.0): RELU=1 -> four outputs of 0; RELU=0 -> four outputs of 16'hFF00.
- Single positive spike 16'h0100 at (2,2), remaining samples -1 (16'hFFFF), RELU=0 -> all four outputs 16'h0100, checking overlap sharing in both axes.
- Ramp from the first scenario with i_data_valid toggling 1-0-0-1 pseudo-randomly -> identical output values and order; each output asserts 1 cycle after its completing sample.
- CHANNELS=2, back-to-back planes (plane 1 = ramp+100) -> 8 outputs: 12, 14, 22, 24, 112, 114, 122, 124. o_plane_done on the 4th and 8th outputs; o_frame_done only on the 8th; o_busy falls on the 8th.
- Assert i_rst_n=0 asynchronously after 13 samples, release, then send a full ramp plane -> no outputs during reset, all outputs 0, then exactly 12, 14, 22, 24.
